// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side port bundle of the dual-clock FIFO: consumer handshake, synchronized
// write pointer in, Gray read pointer and status flags out.
interface async_fifo_rd_ctrl_if #(
    parameter int unsigned ADDRSIZE = 4
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic                ren;
    logic                rempty;
    logic                runderflow;
    logic [ADDRSIZE:0]   rlevel;
    logic                ralmost_empty;

    // master: consumer/synchronizer side; slave: the read controller
    modport master (
        output rinc, rq2_wptr,
        input  rptr, raddr, ren, rempty, runderflow, rlevel, ralmost_empty
    );
    modport slave (
        input  rinc, rq2_wptr,
        output rptr, raddr, ren, rempty, runderflow, rlevel, ralmost_empty
    );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: binary/Gray read pointer, empty,
// sticky underflow. Optional occupancy/almost-empty reporting under RD_LEVEL_EN.
module async_fifo_rd_ctrl #(
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned AE_THRESH = 2
) (
    input logic                  rclk,
    input logic                  rrst_n,
    async_fifo_rd_ctrl_if.slave  rd_if
);
    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] rptr_q;
    logic          rempty_q;
    logic          runderflow_q;
    logic          rd;

    if (AE_THRESH > (2 ** ADDRSIZE)) begin : g_bad_thresh
        $error("AE_THRESH exceeds FIFO depth");
    end

    assign rd        = rd_if.rinc & ~rempty_q;
    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;

    // Empty compares against the next pointer so a read and a write-pointer
    // advance on the same edge are both reflected.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin         <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin     <= rbinnext;
            rptr_q   <= rgraynext;
            rempty_q <= (rgraynext == rd_if.rq2_wptr);
            if (rd_if.rinc && rempty_q)
                runderflow_q <= 1'b1;
        end
    end

    assign rd_if.rptr       = rptr_q;
    assign rd_if.raddr      = rbin[ADDRSIZE-1:0];
    assign rd_if.ren        = rd;
    assign rd_if.rempty     = rempty_q;
    assign rd_if.runderflow = runderflow_q;

`ifdef RD_LEVEL_EN
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rlevel_q;
    logic          ralmost_empty_q;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it
    always_comb begin
        wbin = '0;
        for (int unsigned i = 0; i < PW; i++)
            wbin[i] = ^(rd_if.rq2_wptr >> i);
    end

    assign level_next = wbin - rbinnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel_q        <= '0;
            ralmost_empty_q <= 1'b1;
        end else begin
            rlevel_q        <= level_next;
            ralmost_empty_q <= (level_next <= AE_LIM);
        end
    end

    assign rd_if.rlevel        = rlevel_q;
    assign rd_if.ralmost_empty = ralmost_empty_q;
`else
    assign rd_if.rlevel        = '0;
    assign rd_if.ralmost_empty = rempty_q;
`endif
endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Scoreboard bench for async_fifo_rd_ctrl: accepted-read addresses are queued when
// rinc is driven and popped when ren is observed; state checked after every edge.
module tb_async_fifo_rd_ctrl;
    localparam int unsigned AW  = 4;
    localparam int unsigned AE  = 2;
    localparam int unsigned PW  = AW + 1;

    logic rclk;
    logic rrst_n;

    async_fifo_rd_ctrl_if #(.ADDRSIZE(AW)) rif ();

    async_fifo_rd_ctrl #(.ADDRSIZE(AW), .AE_THRESH(AE)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rd_if  (rif)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned ren_cnt  = 0;

    logic [AW-1:0] sb[$];

    logic [PW-1:0] m_bin;
    logic          m_empty;
    logic          m_uf;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Monitor: every observed RAM read must match the oldest queued address
    always @(negedge rclk) begin
        if (rrst_n && rif.ren) begin
            ren_cnt++;
            if (sb.size() == 0)
                check_val("sb_extra_read", 32'd1, 32'd0);
            else
                check_val("sb_raddr", rif.raddr, sb.pop_front());
        end
    end

    task automatic check_state(input string tag);
        logic [PW-1:0] lvl;
        check_val({tag, "_rptr"},       rif.rptr,       gray(m_bin));
        check_val({tag, "_raddr"},      rif.raddr,      m_bin[AW-1:0]);
        check_val({tag, "_rempty"},     rif.rempty,     m_empty);
        check_val({tag, "_runderflow"}, rif.runderflow, m_uf);
`ifdef RD_LEVEL_EN
        lvl = g2b(rif.rq2_wptr) - m_bin;
        check_val({tag, "_rlevel"},        rif.rlevel,        lvl);
        check_val({tag, "_ralmost_empty"}, rif.ralmost_empty, (lvl <= AE));
`else
        lvl = '0;
        check_val({tag, "_rlevel"},        rif.rlevel,        lvl);
        check_val({tag, "_ralmost_empty"}, rif.ralmost_empty, m_empty);
`endif
    endtask

    // Called at posedge+1: drive rinc, check ren, advance one edge, check state.
    task automatic cyc(input logic inc, input string tag);
        logic acc;
        rif.rinc = inc;
        #1;
        acc = inc && !m_empty;
        check_val({tag, "_ren"}, rif.ren, acc);
        if (inc && m_empty) m_uf = 1'b1;
        if (acc) sb.push_back(m_bin[AW-1:0]);
        @(posedge rclk);
        #1;
        m_bin   = m_bin + {{AW{1'b0}}, acc};
        m_empty = (gray(m_bin) == rif.rq2_wptr);
        check_state(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_rptr"},          rif.rptr,          32'd0);
        check_val({tag, "_raddr"},         rif.raddr,         32'd0);
        check_val({tag, "_rempty"},        rif.rempty,        32'd1);
        check_val({tag, "_runderflow"},    rif.runderflow,    32'd0);
        check_val({tag, "_rlevel"},        rif.rlevel,        32'd0);
        check_val({tag, "_ralmost_empty"}, rif.ralmost_empty, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] exp_rptr [3];
        logic [PW-1:0] prev_rptr;
        logic [AW-1:0] prev_addr;
        int unsigned   ren_base;
        int unsigned   wrap_seen;
        int unsigned   addr_wrap_seen;

        exp_rptr[0] = 5'b00001;
        exp_rptr[1] = 5'b00011;
        exp_rptr[2] = 5'b00010;

        rrst_n       = 1'b0;
        rif.rinc     = 1'b0;
        rif.rq2_wptr = '0;
        m_bin = '0; m_empty = 1'b1; m_uf = 1'b0;

        // Reset held, then released away from the clock edge
        repeat (3) @(posedge rclk);
        #1;
        check_reset_vals("t1_reset");
        rrst_n = 1'b1;
        cyc(1'b0, "t1_idle");

        // Three entries, three reads
        rif.rq2_wptr = gray(5'd3);
        cyc(1'b0, "t2_fill");
        check_val("t2_rempty_low", rif.rempty, 32'd0);
        ren_base = ren_cnt;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, "t2_read");
            check_val("t2_rptr_step", rif.rptr, exp_rptr[i]);
            check_val("t2_raddr_step", rif.raddr, i + 1);
        end
        check_val("t2_empty_after_last", rif.rempty, 32'd1);
        rif.rinc = 1'b0;
        #1;
        check_val("t2_ren_count", ren_cnt - ren_base, 32'd3);

        // Read while empty
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, "t3_uflow");
            check_val("t3_rptr_hold", rif.rptr, 32'b00010);
            check_val("t3_raddr_hold", rif.raddr, 32'd3);
        end
        cyc(1'b0, "t3_idle");
        check_val("t3_uflow_sticky", rif.runderflow, 32'd1);

        // Wrap-around with the write pointer advancing alongside every read
        rif.rq2_wptr = gray(m_bin + 5'd2);
        cyc(1'b0, "t4_prime");
        wrap_seen = 0;
        addr_wrap_seen = 0;
        for (int i = 0; i < 32; i++) begin
            prev_rptr = rif.rptr;
            prev_addr = rif.raddr;
            rif.rq2_wptr = gray(m_bin + 5'd2);
            cyc(1'b1, "t4_wrap");
            check_val("t4_one_bit_toggle", $countones(prev_rptr ^ rif.rptr), 32'd1);
            if (prev_rptr == 5'b10000 && rif.rptr == 5'b00000) wrap_seen++;
            if (prev_addr == 4'd15 && rif.raddr == 4'd0) addr_wrap_seen++;
        end
        check_val("t4_rptr_wrap_seen", wrap_seen, 32'd1);
        check_val("t4_raddr_wrap_seen", addr_wrap_seen, 32'd2);

        // Advance to rbin = 7, then reset mid-read
        rif.rq2_wptr = gray(5'd10);
        while (m_bin != 5'd7) cyc(1'b1, "t6_adv");
        rif.rinc = 1'b1;
        #2;
        check_val("t6_pre_raddr", rif.raddr, 32'd7);
        rrst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        check_val("t6_ren_in_reset", rif.ren, 32'd0);
        @(posedge rclk);
        #1;
        check_reset_vals("t6_held");
        rif.rinc = 1'b0;
        rif.rq2_wptr = '0;
        m_bin = '0; m_empty = 1'b1; m_uf = 1'b0;
        rrst_n = 1'b1;
        cyc(1'b0, "t6_after");

        // Level reporting from a full FIFO down to the threshold
        rif.rq2_wptr = 5'b11000;
        cyc(1'b0, "t5_full");
`ifdef RD_LEVEL_EN
        check_val("t5_level16", rif.rlevel, 32'd16);
        check_val("t5_ae_full", rif.ralmost_empty, 32'd0);
`endif
        for (int i = 0; i < 14; i++) cyc(1'b1, "t5_drain");
`ifdef RD_LEVEL_EN
        check_val("t5_level2", rif.rlevel, 32'd2);
        check_val("t5_ae_low", rif.ralmost_empty, 32'd1);
`endif
        cyc(1'b0, "t5_idle");

        check_val("sb_left", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
